// File: rtl/generic_sram_port_arbiter_pkg.sv
// Shared types for the two-port SRAM arbiter: FSM state encoding and requester index width.
package generic_sram_arb_pkg;

  localparam int unsigned NUM_REQ   = 2;
  localparam int unsigned REQ_IDX_W = 1;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  typedef enum logic [1:0] {
    START = 2'd0,
    INIT  = 2'd1,
    RUN   = 2'd2
  } arb_state_e;

  // Round-robin hand-off: with two requesters the loser is simply the other index.
  function automatic req_idx_t other_req(input req_idx_t r);
    return ~r;
  endfunction

endpackage

// File: rtl/generic_sram_port_arbiter_if.sv
// Request/response bundle for both requesters of the SRAM port arbiter.
interface generic_sram_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH    = 128,
  parameter int unsigned ADDRESS_WIDTH = 7
);

  logic                     i_req_valid_0;
  logic                     o_req_ready_0;
  logic                     i_req_write_0;
  logic [ADDRESS_WIDTH-1:0] i_req_address_0;
  logic [DATA_WIDTH-1:0]    i_req_write_data_0;
  logic                     o_rsp_valid_0;
  logic [DATA_WIDTH-1:0]    o_rsp_read_data_0;

  logic                     i_req_valid_1;
  logic                     o_req_ready_1;
  logic                     i_req_write_1;
  logic [ADDRESS_WIDTH-1:0] i_req_address_1;
  logic [DATA_WIDTH-1:0]    i_req_write_data_1;
  logic                     o_rsp_valid_1;
  logic [DATA_WIDTH-1:0]    o_rsp_read_data_1;

  // Arbiter side.
  modport slave (
    input  i_req_valid_0, i_req_write_0, i_req_address_0, i_req_write_data_0,
    input  i_req_valid_1, i_req_write_1, i_req_address_1, i_req_write_data_1,
    output o_req_ready_0, o_rsp_valid_0, o_rsp_read_data_0,
    output o_req_ready_1, o_rsp_valid_1, o_rsp_read_data_1
  );

  // Requester side.
  modport master (
    output i_req_valid_0, i_req_write_0, i_req_address_0, i_req_write_data_0,
    output i_req_valid_1, i_req_write_1, i_req_address_1, i_req_write_data_1,
    input  o_req_ready_0, o_rsp_valid_0, o_rsp_read_data_0,
    input  o_req_ready_1, o_rsp_valid_1, o_rsp_read_data_1
  );

endinterface

// File: rtl/generic_sram_rsp_pipe.sv
// Read-response delay line: carries a valid bit and requester tag LATENCY cycles.
module generic_sram_rsp_pipe
  import generic_sram_arb_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_valid,
  input  req_idx_t i_tag,
  output logic     o_valid,
  output req_idx_t o_tag
);

  logic [LATENCY-1:0] valid_q;
  req_idx_t           tag_q [LATENCY];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= i_valid;
      tag_q[0]   <= i_tag;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign o_valid = valid_q[LATENCY-1];
  assign o_tag   = tag_q[LATENCY-1];

endmodule

// File: rtl/generic_sram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port SRAM, with optional
// clear-after-reset sweep and fixed-latency read responses.
module generic_sram_port_arbiter
  import generic_sram_arb_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH    = 128,
  parameter int unsigned           ADDRESS_WIDTH = 7,
  parameter int unsigned           READ_LATENCY  = 2,
  parameter bit                    INIT_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  generic_sram_port_arbiter_if.slave req_bus,
  output logic [ADDRESS_WIDTH-1:0] o_sram_address,
  output logic [DATA_WIDTH-1:0]    o_sram_write_data,
  output logic                     o_sram_write_enable,
  input  logic [DATA_WIDTH-1:0]    i_sram_read_data,
  output logic                     o_init_done
);

  arb_state_e               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  req_idx_t                 ptr_q, ptr_d;

  logic [1:0]               req_valid;
  req_idx_t                 grant;
  logic                     accept;
  logic                     acc_write;
  logic [ADDRESS_WIDTH-1:0] acc_address;
  logic [DATA_WIDTH-1:0]    acc_write_data;

  logic                     pipe_valid;
  req_idx_t                 pipe_tag;

  assign req_valid = {req_bus.i_req_valid_1, req_bus.i_req_valid_0};

  // Contention goes to the pointer; a lone requester always wins.
  always_comb begin
    grant = '0;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ptr_q;
      default: grant = '0;
    endcase
  end

  assign accept = (state_q == RUN) && (req_valid != 2'b00);

  assign acc_write      = grant ? req_bus.i_req_write_1      : req_bus.i_req_write_0;
  assign acc_address    = grant ? req_bus.i_req_address_1    : req_bus.i_req_address_0;
  assign acc_write_data = grant ? req_bus.i_req_write_data_1 : req_bus.i_req_write_data_0;

  assign req_bus.o_req_ready_0 = accept && (grant == 1'b0);
  assign req_bus.o_req_ready_1 = accept && (grant == 1'b1);

  always_comb begin
    state_d             = state_q;
    clr_cnt_d           = clr_cnt_q;
    ptr_d               = ptr_q;
    o_sram_address      = '0;
    o_sram_write_data   = '0;
    o_sram_write_enable = 1'b0;

    unique case (state_q)
      START: begin
        state_d = INIT_ON_RESET ? INIT : RUN;
      end
      INIT: begin
        o_sram_address      = clr_cnt_q;
        o_sram_write_data   = INIT_VALUE;
        o_sram_write_enable = 1'b1;
        clr_cnt_d           = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          o_sram_address      = acc_address;
          o_sram_write_data   = acc_write_data;
          o_sram_write_enable = acc_write;
          ptr_d               = other_req(grant);
        end
      end
      default: begin
        state_d = START;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= START;
      clr_cnt_q <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ptr_q     <= ptr_d;
    end
  end

  // Only reads enter the delay line; writes complete silently.
  generic_sram_rsp_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_rsp_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (accept && !acc_write),
    .i_tag   (grant),
    .o_valid (pipe_valid),
    .o_tag   (pipe_tag)
  );

  assign req_bus.o_rsp_valid_0     = pipe_valid && (pipe_tag == 1'b0);
  assign req_bus.o_rsp_valid_1     = pipe_valid && (pipe_tag == 1'b1);
  assign req_bus.o_rsp_read_data_0 = i_sram_read_data;
  assign req_bus.o_rsp_read_data_1 = i_sram_read_data;

  assign o_init_done = (state_q == RUN);

endmodule
